vec_mult_arb: RTL and testbench
===============================

Name: vec_mult_arb

Overview:
- Frame-level round-robin arbiter that shares one vec_mult instance among NUM_REQ operand-pair requesters in the wrd datapath.
- Locks a grant for a whole frame, from the first beat through the last-tagged beat.
- Muxes the granted requester's operands onto the multiplier inputs.
- Steers the multiplier's product stream back to that requester's result port.
- Releases the grant only when the product last-beat handshake completes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- INPUT_BW, 8, element width.
- VECTOR_SIZE, 13, elements per beat.
- VW (localparam), VECTOR_SIZE*INPUT_BW, beat width of operand and product buses.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_data1_i  in  NUM_REQ*VW  operand 1 per requester; requester k occupies slice [k*VW +: VW]
- req_data2_i  in  NUM_REQ*VW  operand 2 per requester, same slicing
- req_valid_i  in  NUM_REQ  operand-beat valid per requester
- req_last_i  in  NUM_REQ  last beat of frame per requester
- req_ready_o  out  NUM_REQ  operand-beat ready per requester
- mult_data1_o  out  VW  to vec_mult data1_i
- mult_data2_o  out  VW  to vec_mult data2_i
- mult_valid_o  out  1  to vec_mult valid1_i and valid2_i
- mult_last_o  out  1  to vec_mult last1_i and last2_i
- mult_ready_i  in  1  from vec_mult ready1_o
- mult_data_i  in  VW  from vec_mult data_o
- mult_valid_i  in  1  from vec_mult valid_o
- mult_last_i  in  1  from vec_mult last_o
- mult_ready_o  out  1  to vec_mult ready_i
- res_data_o  out  VW  product, broadcast to all requesters
- res_valid_o  out  NUM_REQ  product valid, one-hot to the granted requester
- res_last_o  out  1  product last
- res_ready_i  in  NUM_REQ  product ready per requester
- grant_o  out  NUM_REQ  one-hot current grant; 0 when idle
- busy_o  out  1  high while in BUSY

Behaviour:
- Reset (rst_i high, async):
  - state=IDLE, grant_o=0, busy_o=0, sent_last=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - While idle/reset: all req_ready_o=0, mult_valid_o=0, mult_ready_o=0, res_valid_o=0.
  - mult_data1_o, mult_data2_o, res_last_o and mult_last_o are driven 0.
  - A reset mid-frame abandons the frame; no partial-frame recovery.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Register the grant; next cycle state=BUSY.
  - This costs one cycle of arbitration latency; no beat is accepted in the IDLE cycle.
- BUSY with granted index g:
  - mult_data1_o and mult_data2_o = slice g of the operand buses.
  - mult_valid_o = req_valid_i[g] & ~sent_last.
  - mult_last_o = req_last_i[g].
  - req_ready_o[g] = mult_ready_i & ~sent_last; all other ready bits are 0.
  - Product side: res_valid_o[g] = mult_valid_i; mult_ready_o = res_ready_i[g]; res_data_o = mult_data_i; res_last_o = mult_last_i.
- Operand last handshake (mult_valid_o & mult_ready_i & mult_last_o):
  - Set sent_last; no further beats are accepted from g.
- Product last handshake (mult_valid_i & mult_ready_o & mult_last_i):
  - state=IDLE, rr_ptr=g, grant cleared, sent_last cleared.
- Simultaneous operand and product last in the same cycle (the combinational vec_mult case):
  - Go directly to IDLE.
  - sent_last stays 0 in the next cycle.
- Other requesters may hold valid indefinitely while not granted; their ready stays 0. Each gets at most one frame wait per competing requester (round-robin fairness).
- A requester deasserting valid mid-frame keeps its grant; no timeout.
- Frame of one beat: a single beat with last=1 works; there is no minimum length.
- The block adds no data latency; operand and product paths are combinational muxes.
- The grant is always one-hot or zero.

Decomposition:
- Package vec_mult_arb_pkg:
  - state enum {IDLE, BUSY};
  - localparam for ID width $clog2(NUM_REQ).
- Sub-module rr_pick: combinational rotating-priority encoder; inputs req vector and pointer, outputs one-hot pick and a valid flag.
- FSM, grant/pointer registers and muxes stay in vec_mult_arb.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst_i while granted to req1 with 3 of 5 beats sent.
  - Response: grant_o=0 and all valids 0 asynchronously. After release, with both requesters valid, req0 is granted first.
- Single requester:
  - Stimulus: req0 sends a 4-beat frame of data1=all 2s, data2=all 3s.
  - Response: one idle cycle, then 4 res beats for req0 of all 6s; res_last_o on beat 4; busy_o drops the cycle after.
- Contention:
  - Stimulus: req0 and req1 both continuously valid with 2-beat frames.
  - Response: grants alternate 0,1,0,1 with a one-cycle IDLE gap between frames; the non-granted ready stays 0 throughout.
- Backpressure:
  - Stimulus: res_ready_i[g] low for 3 cycles mid-frame.
  - Response: mult_ready_o and req_ready_o[g] low for those cycles; no beat is dropped or duplicated; grant is held.
- Stall and last edge:
  - Stimulus: granted requester drops valid for 5 cycles, then sends a 1-beat last.
  - Response: grant held through the gap; release occurs on that last handshake.
- Pointer wrap:
  - Stimulus: NUM_REQ=3; only req2 and req0 are valid.
  - Response: order is 0,2,0,2; req1 is skipped with no bubble beyond the one-cycle arbitration.

Source files
------------

// File: rtl/vec_mult_arb_pkg.sv
// Shared types and helpers for the vec_mult frame arbiter.
package vec_mult_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned DEFAULT_NUM_REQ = 2;

  // Index width for a requester count; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/vec_mult_arb_rr_pick.sv
// Rotating-priority encoder: first set request strictly after ptr, wrapping.
module rr_pick
  import vec_mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [ID_W-1:0] idx;

  // Walk the requesters starting one past the pointer; the first hit wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_mult_arb.sv
// Frame-level round-robin arbiter sharing one vec_mult among NUM_REQ requesters.
module vec_mult_arb
  import vec_mult_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned INPUT_BW    = 8,
  parameter int unsigned VECTOR_SIZE = 13,
  localparam int unsigned VW         = VECTOR_SIZE * INPUT_BW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ*VW-1:0] req_data1_i,
  input  logic [NUM_REQ*VW-1:0] req_data2_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_last_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [VW-1:0]         mult_data1_o,
  output logic [VW-1:0]         mult_data2_o,
  output logic                  mult_valid_o,
  output logic                  mult_last_o,
  input  logic                  mult_ready_i,
  input  logic [VW-1:0]         mult_data_i,
  input  logic                  mult_valid_i,
  input  logic                  mult_last_i,
  output logic                  mult_ready_o,
  output logic [VW-1:0]         res_data_o,
  output logic [NUM_REQ-1:0]    res_valid_o,
  output logic                  res_last_o,
  input  logic [NUM_REQ-1:0]    res_ready_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  busy_o
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  arb_state_t          state, state_n;
  logic [NUM_REQ-1:0]  grant, grant_n;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
  logic                sent_last, sent_last_n;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_valid;
  logic [ID_W-1:0]     gi;
  logic                g_valid, g_last, g_res_ready;
  logic                op_last, prod_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Select the granted requester's operand slices and control bits; all zero when idle.
  always_comb begin
    mult_data1_o = '0;
    mult_data2_o = '0;
    gi           = '0;
    g_valid      = 1'b0;
    g_last       = 1'b0;
    g_res_ready  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        mult_data1_o = req_data1_i[k*VW +: VW];
        mult_data2_o = req_data2_i[k*VW +: VW];
        gi           = ID_W'(k);
        g_valid      = req_valid_i[k];
        g_last       = req_last_i[k];
        g_res_ready  = res_ready_i[k];
      end
    end
  end

  // Kept as separate assigns so the operand path and the returning product
  // path never share a process when vec_mult is purely combinational.
  assign busy_o       = (state == BUSY);
  assign grant_o      = grant;
  assign mult_valid_o = busy_o & g_valid & ~sent_last;
  assign mult_last_o  = g_last;
  assign req_ready_o  = grant & {NUM_REQ{mult_ready_i & ~sent_last}};
  assign mult_ready_o = g_res_ready;
  assign res_valid_o  = grant & {NUM_REQ{mult_valid_i}};
  assign res_data_o   = mult_data_i;
  assign res_last_o   = busy_o & mult_last_i;

  assign op_last   = mult_valid_o & mult_ready_i & mult_last_o;
  assign prod_last = busy_o & mult_valid_i & mult_ready_o & mult_last_i;

  // Next-state: arbitrate in IDLE, hold the grant until the product last beat.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    sent_last_n = sent_last;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = BUSY;
          grant_n = pick;
        end
      end
      BUSY: begin
        // Product last takes priority so a same-cycle operand last leaves sent_last clear.
        if (prod_last) begin
          state_n     = IDLE;
          grant_n     = '0;
          rr_ptr_n    = gi;
          sent_last_n = 1'b0;
        end else if (op_last) begin
          sent_last_n = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        grant_n     = '0;
        sent_last_n = 1'b0;
      end
    endcase
  end

  // State, grant, pointer and frame-sent registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      sent_last <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_ptr_n;
      sent_last <= sent_last_n;
    end
  end

endmodule

// File: tb/tb_vec_mult_arb.sv
// Directed bench for vec_mult_arb with a combinational vec_mult model.
module tb_vec_mult_arb;

  localparam int unsigned BW = 8;
  localparam int unsigned VS = 13;
  localparam int unsigned VW = VS * BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- two-requester instance ----------------
  logic [2*VW-1:0] req_data1, req_data2;
  logic [1:0]      req_valid, req_last, req_ready, res_valid, res_ready, grant;
  logic [VW-1:0]   m_d1, m_d2, m_dat, res_data;
  logic            m_v, m_l, m_rdy_in, m_vin, m_lin, m_rdy_out, res_last, busy;

  // ---------------- three-requester instance ----------------
  logic [3*VW-1:0] req_data1_3, req_data2_3;
  logic [2:0]      req_valid3, req_last3, req_ready3, res_valid3, res_ready3, grant3;
  logic [VW-1:0]   m_d1_3, m_d2_3, m_dat3, res_data3;
  logic            m_v3, m_l3, m_rdy_in3, m_vin3, m_lin3, m_rdy_out3, res_last3, busy3;

  function automatic logic [VW-1:0] fill(input logic [7:0] v);
    return {VS{v}};
  endfunction

  function automatic logic [VW-1:0] vmul(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    logic [15:0]   p;
    r = '0;
    for (int i = 0; i < int'(VS); i++) begin
      p = 16'(a[i*BW +: BW]) * 16'(b[i*BW +: BW]);
      r[i*BW +: BW] = p[7:0];
    end
    return r;
  endfunction

  // Combinational vec_mult model for both instances.
  assign m_rdy_in  = m_rdy_out;
  assign m_vin     = m_v;
  assign m_lin     = m_l;
  assign m_dat     = vmul(m_d1, m_d2);
  assign m_rdy_in3 = m_rdy_out3;
  assign m_vin3    = m_v3;
  assign m_lin3    = m_l3;
  assign m_dat3    = vmul(m_d1_3, m_d2_3);

  vec_mult_arb #(.NUM_REQ(2), .INPUT_BW(BW), .VECTOR_SIZE(VS)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_data1_i(req_data1), .req_data2_i(req_data2),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_ready_o(req_ready),
    .mult_data1_o(m_d1), .mult_data2_o(m_d2), .mult_valid_o(m_v), .mult_last_o(m_l),
    .mult_ready_i(m_rdy_in), .mult_data_i(m_dat), .mult_valid_i(m_vin),
    .mult_last_i(m_lin), .mult_ready_o(m_rdy_out),
    .res_data_o(res_data), .res_valid_o(res_valid), .res_last_o(res_last),
    .res_ready_i(res_ready), .grant_o(grant), .busy_o(busy)
  );

  vec_mult_arb #(.NUM_REQ(3), .INPUT_BW(BW), .VECTOR_SIZE(VS)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_data1_i(req_data1_3), .req_data2_i(req_data2_3),
    .req_valid_i(req_valid3), .req_last_i(req_last3), .req_ready_o(req_ready3),
    .mult_data1_o(m_d1_3), .mult_data2_o(m_d2_3), .mult_valid_o(m_v3), .mult_last_o(m_l3),
    .mult_ready_i(m_rdy_in3), .mult_data_i(m_dat3), .mult_valid_i(m_vin3),
    .mult_last_i(m_lin3), .mult_ready_o(m_rdy_out3),
    .res_data_o(res_data3), .res_valid_o(res_valid3), .res_last_o(res_last3),
    .res_ready_i(res_ready3), .grant_o(grant3), .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e2;
    logic [2:0] e3;

    rst         = 1'b1;
    req_valid   = '0;
    req_last    = '0;
    res_ready   = 2'b11;
    req_data1   = {fill(8'd4), fill(8'd2)};
    req_data2   = {fill(8'd5), fill(8'd3)};
    req_valid3  = '0;
    req_last3   = '0;
    res_ready3  = 3'b111;
    req_data1_3 = {fill(8'd5), fill(8'd9), fill(8'd2)};
    req_data2_3 = {fill(8'd5), fill(8'd9), fill(8'd3)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_mult_valid", m_v, 1'b0);
    chk("rst_res_valid", res_valid, 2'b00);
    chk("rst_mult_data1", m_d1, '0);
    chk("rst_mult_last", m_l, 1'b0);
    chk("rst_res_last", res_last, 1'b0);
    chk("rst_grant3", grant3, 3'b000);
    rst = 1'b0;
    tick();

    // Single requester, 4-beat frame of 2*3
    req_valid = 2'b01;
    #1;
    chk("sr_idle_ready", req_ready, 2'b00);
    chk("sr_idle_busy", busy, 1'b0);
    tick();
    for (int b = 1; b <= 4; b++) begin
      req_last = (b == 4) ? 2'b01 : 2'b00;
      #1;
      chk("sr_grant", grant, 2'b01);
      chk("sr_ready", req_ready, 2'b01);
      chk("sr_res_valid", res_valid, 2'b01);
      chk("sr_data", res_data, fill(8'd6));
      chk("sr_last", res_last, (b == 4));
      tick();
    end
    req_valid = 2'b00;
    req_last  = 2'b00;
    #1;
    chk("sr_busy_drop", busy, 1'b0);
    chk("sr_grant_drop", grant, 2'b00);

    // Reset mid-frame: req1 granted, 3 of 5 beats sent
    req_valid = 2'b10;
    tick();
    for (int b = 1; b <= 3; b++) begin
      #1;
      chk("rm_grant", grant, 2'b10);
      chk("rm_mult_data1", m_d1, fill(8'd4));
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rm_grant_clr", grant, 2'b00);
    chk("rm_res_valid", res_valid, 2'b00);
    chk("rm_mult_valid", m_v, 1'b0);
    chk("rm_req_ready", req_ready, 2'b00);
    chk("rm_busy", busy, 1'b0);
    tick();
    rst       = 1'b0;
    req_valid = 2'b11;

    // Contention: 2-beat frames, grants alternate starting at req0
    for (int f = 0; f < 4; f++) begin
      e2 = (f % 2 == 1) ? 2'b10 : 2'b01;
      req_last = 2'b00;
      #1;
      chk("ct_idle_grant", grant, 2'b00);
      chk("ct_idle_ready", req_ready, 2'b00);
      tick();
      #1;
      chk("ct_grant", grant, e2);
      chk("ct_ready", req_ready, e2);
      chk("ct_res_valid", res_valid, e2);
      chk("ct_data", res_data, fill((f % 2 == 1) ? 8'd20 : 8'd6));
      tick();
      req_last = 2'b11;
      #1;
      chk("ct_ready2", req_ready, e2);
      chk("ct_last", res_last, 1'b1);
      tick();
    end

    // Backpressure: res_ready low for 3 cycles on beat 2
    req_valid = 2'b01;
    req_last  = 2'b00;
    req_data1[0 +: VW] = fill(8'd1);
    #1;
    chk("bp_idle_busy", busy, 1'b0);
    tick();
    #1;
    chk("bp_beat1", res_data, fill(8'd3));
    tick();
    req_data1[0 +: VW] = fill(8'd2);
    res_ready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_mult_ready", m_rdy_out, 1'b0);
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_grant", grant, 2'b01);
      tick();
    end
    res_ready = 2'b11;
    #1;
    chk("bp_beat2", res_data, fill(8'd6));
    chk("bp_req_ready_back", req_ready, 2'b01);
    tick();
    req_data1[0 +: VW] = fill(8'd3);
    #1;
    chk("bp_beat3", res_data, fill(8'd9));
    tick();
    req_data1[0 +: VW] = fill(8'd4);
    req_last = 2'b01;
    #1;
    chk("bp_beat4", res_data, fill(8'd12));
    chk("bp_last", res_last, 1'b1);
    tick();
    req_valid = 2'b00;
    req_last  = 2'b00;
    #1;
    chk("bp_release", busy, 1'b0);

    // Stall: req1 drops valid for 5 cycles, then a 1-beat last
    req_valid = 2'b10;
    tick();
    #1;
    chk("st_grant", grant, 2'b10);
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("st_hold_grant", grant, 2'b10);
      chk("st_hold_res_valid", res_valid, 2'b00);
      chk("st_hold_busy", busy, 1'b1);
      tick();
    end
    req_valid = 2'b10;
    req_last  = 2'b10;
    #1;
    chk("st_last", res_last, 1'b1);
    chk("st_last_valid", res_valid, 2'b10);
    tick();
    req_valid = 2'b00;
    req_last  = 2'b00;
    #1;
    chk("st_release_grant", grant, 2'b00);
    chk("st_release_busy", busy, 1'b0);

    // Pointer wrap on three requesters: req0 and req2 only, 1-beat frames
    req_valid3 = 3'b101;
    req_last3  = 3'b111;
    for (int f = 0; f < 4; f++) begin
      e3 = (f % 2 == 1) ? 3'b100 : 3'b001;
      #1;
      chk("pw_idle_grant", grant3, 3'b000);
      tick();
      #1;
      chk("pw_grant", grant3, e3);
      chk("pw_ready", req_ready3, e3);
      chk("pw_data", res_data3, fill((f % 2 == 1) ? 8'd25 : 8'd6));
      chk("pw_last", res_last3, 1'b1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
